mic1_mem_arbiter: RTL and testbench

Sits between the mic1 core and a single-port 32-bit byte-addressed RAM. It serialises the core's three memory operations (data write, data read, instruction fetch) onto one port and holds the core stalled through its `run` input until every requested operation has completed. It then presents read data on the core's `mem_rdata` / `mem_rd_instr` for exactly the cycle in which the core samples them.

---
 rtl/mic1_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mic1_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic1_mem_arbiter.sv
// rtl/mic1_mem_arbiter.sv - serialises mic1 write/read/fetch onto one RAM port and stalls the core meanwhile
module mic1_mem_arbiter #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        run_in,
  output logic        run_out,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_fetch,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic [31:0] mem_addr_instr,
  output logic [7:0]  mem_rd_instr,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack,
  output logic [31:0] stall_cycles
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_IF   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       wd;
  logic       rd;
  logic       fd;
  logic [2:0] pending;
  logic [1:0] lane;
  logic [7:0] fetch_byte;
  logic       unused_addr_bits;

  assign unused_addr_bits = &{1'b0, mem_addr[31:30]};

  // Bit 2 = write, bit 1 = read, bit 0 = fetch; priority follows bit order.
  assign pending = {mem_write, mem_read, mem_fetch} & ~{wd, rd, fd};

  function automatic logic [2:0] pick(input logic [2:0] mask);
    logic [2:0] s;
    if (mask[2])      s = S_WR;
    else if (mask[1]) s = S_RD;
    else if (mask[0]) s = S_IF;
    else              s = S_DONE;
    return s;
  endfunction

  assign run_out = run_in & ((state == S_DONE) | ((state == S_IDLE) & (pending == 3'b000)));

  // Big-endian byte 0 lives in the top lane, so the lane index is the inverted offset.
  assign lane       = BIG_ENDIAN ? ~mem_addr_instr[1:0] : mem_addr_instr[1:0];
  assign fetch_byte = ram_rdata[{lane, 3'b000} +: 8];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (run_in && (pending != 3'b000)) state_nxt = pick(pending);
      S_WR:   if (ram_ack) state_nxt = pick(pending & 3'b011);
      S_RD:   if (ram_ack) state_nxt = pick(pending & 3'b101);
      S_IF:   if (ram_ack) state_nxt = pick(pending & 3'b110);
      S_DONE: if (run_in) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = 32'h0;
    ram_wdata = 32'h0;
    case (state)
      S_WR: begin
        ram_req   = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = {mem_addr[29:0], 2'b00};
        ram_wdata = mem_wdata;
      end
      S_RD: begin
        ram_req  = 1'b1;
        ram_addr = {mem_addr[29:0], 2'b00};
      end
      S_IF: begin
        ram_req  = 1'b1;
        ram_addr = {mem_addr_instr[31:2], 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      wd           <= 1'b0;
      rd           <= 1'b0;
      fd           <= 1'b0;
      mem_rdata    <= 32'h0;
      mem_rd_instr <= 8'h0;
      stall_cycles <= 32'h0;
    end else begin
      state <= state_nxt;
      case (state)
        S_WR: if (ram_ack) wd <= 1'b1;
        S_RD: if (ram_ack) begin
          rd        <= 1'b1;
          mem_rdata <= ram_rdata;
        end
        S_IF: if (ram_ack) begin
          fd           <= 1'b1;
          mem_rd_instr <= fetch_byte;
        end
        S_DONE: if (run_in) begin
          wd <= 1'b0;
          rd <= 1'b0;
          fd <= 1'b0;
        end
        default: ;
      endcase
      if (run_in && !run_out) stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_mic1_mem_arbiter.sv
// tb/tb_mic1_mem_arbiter.sv - randomized self-checking bench for mic1_mem_arbiter against a transaction model
module tb_mic1_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        run_in = 1'b1;
  logic        run_out;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_fetch = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr_instr = 32'h0;
  logic [7:0]  mem_rd_instr;
  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic [31:0] stall_cycles;

  logic        unused_le_run_out;
  logic [31:0] le_mem_rdata;
  logic [7:0]  le_mem_rd_instr;
  logic        unused_le_req;
  logic        unused_le_we;
  logic [31:0] unused_le_addr;
  logic [31:0] unused_le_wdata;
  logic [31:0] unused_le_stall;

  logic [31:0] ram   [0:1023];
  logic [31:0] model [0:1023];
  int          wait_target = 0;
  int          wcnt = 0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_rdata = 32'h0;
  logic [7:0]  exp_be = 8'h0;
  logic [7:0]  exp_le = 8'h0;
  logic [32:0] acc_q[$];
  int          req_cycles;
  int          addr_moves;
  int          last_stalls;

  always #5 clk = ~clk;

  mic1_mem_arbiter #(.BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .run_in(run_in), .run_out(run_out),
    .mem_read(mem_read), .mem_write(mem_write), .mem_fetch(mem_fetch),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_instr(mem_addr_instr), .mem_rd_instr(mem_rd_instr),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack), .stall_cycles(stall_cycles)
  );

  mic1_mem_arbiter #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .resetn(resetn), .run_in(run_in), .run_out(unused_le_run_out),
    .mem_read(mem_read), .mem_write(mem_write), .mem_fetch(mem_fetch),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(le_mem_rdata),
    .mem_addr_instr(mem_addr_instr), .mem_rd_instr(le_mem_rd_instr),
    .ram_req(unused_le_req), .ram_we(unused_le_we), .ram_addr(unused_le_addr),
    .ram_wdata(unused_le_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .stall_cycles(unused_le_stall)
  );

  // RAM responder: acks after wait_target cycles of continuous request.
  always @(posedge clk) begin
    if (!ram_req || ram_ack) wcnt <= 0;
    else                     wcnt <= wcnt + 1;
  end
  assign ram_ack   = ram_req && (wcnt >= wait_target);
  assign ram_rdata = ram[ram_addr[11:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_fetch_expect(input logic [31:0] word, input logic [1:0] off);
    logic [31:0] t;
    t = word >> (8 * (3 - int'(off)));
    exp_be = t[7:0];
    t = word >> (8 * int'(off));
    exp_le = t[7:0];
  endtask

  task automatic txn(input bit w, input bit r, input bit f, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] ia, input int waits);
    logic [32:0] exp_q[$];
    logic [31:0] sc0;
    logic [31:0] prev_addr;
    bit          prev_req;
    bit          done;
    int          nops;
    int          exp_st;
    int          st;
    mem_write = w; mem_read = r; mem_fetch = f;
    mem_addr = a; mem_wdata = d; mem_addr_instr = ia; wait_target = waits;
    if (w) begin
      model[a[9:0]] = d;
      exp_q.push_back({1'b1, a[29:0], 2'b00});
    end
    if (r) begin
      exp_rdata = model[a[9:0]];
      exp_q.push_back({1'b0, a[29:0], 2'b00});
    end
    if (f) begin
      set_fetch_expect(model[ia[11:2]], ia[1:0]);
      exp_q.push_back({1'b0, ia[31:2], 2'b00});
    end
    nops   = int'(w) + int'(r) + int'(f);
    exp_st = nops * (1 + waits) + ((nops > 0) ? 1 : 0);
    sc0 = stall_cycles;
    acc_q.delete();
    st = 0; req_cycles = 0; addr_moves = 0; prev_req = 0; prev_addr = 32'h0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (run_out) done = 1;
      else begin
        st++;
        if (ram_req) begin
          req_cycles++;
          if (prev_req && ram_addr != prev_addr) addr_moves++;
          prev_addr = ram_addr;
          prev_req  = !ram_ack;
          if (ram_ack) begin
            acc_q.push_back({ram_we, ram_addr});
            if (ram_we) ram[ram_addr[11:2]] = ram_wdata;
          end
        end else prev_req = 0;
        @(posedge clk); #1;
      end
    end
    last_stalls = st;
    chk("done_reached", 32'(done), 32'd1);
    chk("stall_observed", st, exp_st);
    chk("stall_counter_delta", stall_cycles - sc0, exp_st);
    chk("mem_rdata", mem_rdata, exp_rdata);
    chk("mem_rd_instr_be", 32'(mem_rd_instr), 32'(exp_be));
    chk("mem_rd_instr_le", 32'(le_mem_rd_instr), 32'(exp_le));
    chk("access_count", acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      chk("access_we", 32'(acc_q[i][32]), 32'(exp_q[i][32]));
      chk("access_addr", acc_q[i][31:0], exp_q[i][31:0]);
    end
    @(posedge clk); #1;
    mem_write = 0; mem_read = 0; mem_fetch = 0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] ia;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      ram[i] = v;
      model[i] = v;
    end
    ram[16'h10] = 32'hDEADBEEF; model[16'h10] = 32'hDEADBEEF;
    ram[16'h40] = 32'h11223344; model[16'h40] = 32'h11223344;

    #2;
    chk("reset_run_out", 32'(run_out), 32'd1);
    chk("reset_ram_req", 32'(ram_req), 32'd0);
    chk("reset_ram_we", 32'(ram_we), 32'd0);
    chk("reset_ram_addr", ram_addr, 32'h0);
    chk("reset_ram_wdata", ram_wdata, 32'h0);
    chk("reset_mem_rdata", mem_rdata, 32'h0);
    chk("reset_mem_rd_instr", 32'(mem_rd_instr), 32'h0);
    chk("reset_stall_cycles", stall_cycles, 32'h0);
    @(posedge clk); #3;
    resetn = 1'b1;
    @(posedge clk); #1;

    txn(0, 1, 0, 32'h10, 32'h0, 32'h0, 0);
    chk("read_first_addr", (acc_q.size() > 0) ? acc_q[0][31:0] : 32'hFFFFFFFF, 32'h40);
    chk("read_data_const", mem_rdata, 32'hDEADBEEF);
    chk("read_stall_abs", stall_cycles, 32'd2);

    txn(0, 0, 1, 32'h0, 32'h0, 32'h102, 0);
    chk("fetch_be_const", 32'(mem_rd_instr), 32'h33);
    chk("fetch_le_const", 32'(le_mem_rd_instr), 32'h22);

    txn(1, 1, 1, 32'h5, 32'hCAFEF00D, 32'h200, 0);
    chk("rw_data_const", mem_rdata, 32'hCAFEF00D);
    chk("rw_stalls_const", last_stalls, 32'd4);

    txn(0, 1, 0, 32'h33, 32'h0, 32'h0, 3);
    chk("wait_stalls_const", last_stalls, 32'd5);
    chk("wait_req_cycles", req_cycles, 32'd4);
    chk("wait_addr_steady", addr_moves, 32'd0);

    // run_in dropped while the read is waiting for ack
    mem_read = 1; mem_addr = 32'd7; wait_target = 2;
    exp_rdata = model[7];
    @(posedge clk); #1;
    run_in = 0;
    repeat (4) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drop_run_out_held", 32'(run_out), 32'd0);
    chk("drop_ram_req_idle", 32'(ram_req), 32'd0);
    chk("drop_rdata", mem_rdata, exp_rdata);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_run_out_still", 32'(run_out), 32'd0);
    chk("drop_rdata_stable", mem_rdata, exp_rdata);
    @(posedge clk); #1;
    run_in = 1;
    @(negedge clk);
    chk("drop_resume_run_out", 32'(run_out), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_idle_stall", 32'(run_out), 32'd0);
    chk("drop_idle_no_req", 32'(ram_req), 32'd0);
    mem_read = 0;
    #1;
    chk("drop_idle_clear", 32'(run_out), 32'd1);
    @(posedge clk); #1;
    wait_target = 0;

    // async reset while a read is waiting
    mem_read = 1; mem_addr = 32'd9; wait_target = 10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("arst_pre_req", 32'(ram_req), 32'd1);
    #2;
    resetn = 0;
    #1;
    chk("arst_ram_req", 32'(ram_req), 32'd0);
    chk("arst_stall", stall_cycles, 32'd0);
    chk("arst_rdata", mem_rdata, 32'h0);
    mem_read = 0;
    exp_rdata = 32'h0; exp_be = 8'h0; exp_le = 8'h0;
    @(posedge clk); #3;
    resetn = 1;
    wait_target = 0;
    @(negedge clk);
    chk("arst_idle_run_out", 32'(run_out), 32'd1);
    chk("arst_idle_req", 32'(ram_req), 32'd0);
    chk("arst_idle_stall", stall_cycles, 32'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) == 0) ia = {20'h0, a[9:0], 2'(($urandom_range(0, 3)))};
      else ia = 32'($urandom_range(0, 4095));
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          a, $urandom, ia, int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
